// File: rtl/eth_pkg.sv
// Shared types and default timing for the 10BASE-T transmit scheduler.
package eth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StSend,
        StGap
    } eth_state_e;

    // 20 MHz clock: one Manchester half-bit per cycle
    localparam int unsigned ETH_FRAME_CYCLES = 1200;
    localparam int unsigned ETH_IFG_CYCLES   = 192;

endpackage

// File: rtl/eth_rr_arb.sv
// Combinational round-robin picker: first set req at or above rr_ptr, wrapping.
// With ETH_TX_SCHED_PRIO_EN defined, requester 0 bypasses the rotation.
module eth_rr_arb
    import eth_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned SELW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [SELW-1:0]  rr_ptr_i,
    output logic [SELW-1:0]  winner_o,
    output logic             valid_o
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;

    // Rotate so that bit 0 of req_rot is the requester at rr_ptr
    assign req_dbl = {req_i, req_i} >> rr_ptr_i;
    assign req_rot = req_dbl[N_REQ-1:0];

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        // Descending scan so the lowest rotated offset is the last write
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                valid_o = 1'b1;
                if (int'(rr_ptr_i) + i >= int'(N_REQ)) begin
                    winner_o = SELW'(int'(rr_ptr_i) + i - int'(N_REQ));
                end else begin
                    winner_o = SELW'(int'(rr_ptr_i) + i);
                end
            end
        end
`ifdef ETH_TX_SCHED_PRIO_EN
        if (req_i[0]) begin
            winner_o = '0;
            valid_o  = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Round-robin frame scheduler for a shared 10BASE-T transmitter; times frame and gap itself.
// Optional strict priority for requester 0 via ETH_TX_SCHED_PRIO_EN.
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned FRAME_CYCLES = ETH_FRAME_CYCLES,
    parameter int unsigned IFG_CYCLES   = ETH_IFG_CYCLES,
    localparam int unsigned SELW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SELW-1:0]  sel,
    output logic             start,
    output logic             busy,
    output logic [N_REQ-1:0] done
);

    localparam int unsigned MAXC = (FRAME_CYCLES > IFG_CYCLES) ? FRAME_CYCLES : IFG_CYCLES;
    localparam int unsigned TW   = $clog2(MAXC);

    eth_state_e       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] done_q, done_d;

    logic [SELW-1:0]  arb_winner;
    logic             arb_valid;

    eth_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (arb_winner),
        .valid_o  (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        start_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = '0;

        unique case (state_q)
            StIdle: begin
                if (enable && arb_valid) begin
                    state_d = StStart;
                    gnt_d   = N_REQ'(1) << arb_winner;
                    sel_d   = arb_winner;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                timer_d = TW'(FRAME_CYCLES - 1);
                state_d = StSend;
            end
            StSend: begin
                if (timer_q == '0) begin
                    timer_d = TW'(IFG_CYCLES - 1);
                    state_d = StGap;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StGap: begin
                if (timer_q == '0) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    if (N_REQ > 1) begin
`ifdef ETH_TX_SCHED_PRIO_EN
                        if (sel_q != '0) begin
                            rr_ptr_d = (sel_q == SELW'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
                        end
`else
                        rr_ptr_d = (sel_q == SELW'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
`endif
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // done is registered, so raise it on entry to the final gap cycle
        if (state_d == StGap && timer_d == '0) begin
            done_d = gnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            sel_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign start = start_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed table-driven bench for eth_tx_sched (N_REQ=4, FRAME_CYCLES=8, IFG_CYCLES=4).
// Each row: inputs held for one clock, outputs checked 1 time unit after the edge.
module tb_eth_tx_sched;

    localparam int F = 8;
    localparam int I = 4;
    localparam int BUSY_ROWS = F + I - 1;
    localparam int MAX_CYCLES = 5000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       start;
    logic       busy;
    logic [3:0] done;
    logic       run_done = 1'b0;

    eth_tx_sched #(
        .N_REQ        (4),
        .FRAME_CYCLES (F),
        .IFG_CYCLES   (I)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .req    (req),
        .gnt    (gnt),
        .sel    (sel),
        .start  (start),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic       rst_n;
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       start;
        logic       busy;
        logic [3:0] done;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(int tag, logic r, logic e, logic [3:0] rq, logic [3:0] g,
                                logic [1:0] s, logic st, logic b, logic [3:0] d);
        vec_t v;
        v.tag = tag; v.rst_n = r; v.en = e; v.req = rq;
        v.gnt = g; v.sel = s; v.start = st; v.busy = b; v.done = d;
        vecs.push_back(v);
    endfunction

    function automatic void add_reset(int tag);
        add(tag, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
    endfunction

    // One full frame from the START cycle through the following IDLE cycle
    function automatic void add_frame(int tag, logic [3:0] req_s, logic en_s,
                                      logic [3:0] req_r, logic en_r, int g);
        logic [3:0] gv;
        gv = 4'b0001 << g;
        add(tag, 1'b1, en_s, req_s, gv, 2'(g), 1'b1, 1'b1, 4'b0000);
        for (int k = 0; k < BUSY_ROWS; k++) begin
            add(tag, 1'b1, en_r, req_r, gv, 2'(g), 1'b0, 1'b1, 4'b0000);
        end
        add(tag, 1'b1, en_r, req_r, gv, 2'(g), 1'b0, 1'b1, gv);
        add(tag, 1'b1, en_r, req_r, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
    endfunction

    function automatic void add_idle(int tag, logic e, logic [3:0] rq);
        add(tag, 1'b1, e, rq, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
    endfunction

    initial begin
        repeat (MAX_CYCLES) @(posedge clk);
        if (!run_done) begin
            n_err++;
            $display("FAIL timeout: run not finished after %0d cycles", MAX_CYCLES);
            $display("TEST FAILED");
            $finish;
        end
    end

    initial begin
        int order2[5];
        order2 = '{0, 1, 2, 3, 0};

        // 1: single request, re-served after the idle cycle
        add_reset(1);
        add_frame(1, 4'b0010, 1'b1, 4'b0010, 1'b1, 1);
        add(1, 1'b1, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0000);

`ifdef ETH_TX_SCHED_PRIO_EN
        // 6: requester 0 always wins; rr_ptr parked at 3 survives req0 frames
        add_reset(6);
        add_frame(6, 4'b0100, 1'b1, 4'b0100, 1'b1, 2);
        add_frame(6, 4'b1111, 1'b1, 4'b1111, 1'b1, 0);
        add_frame(6, 4'b1111, 1'b1, 4'b1111, 1'b1, 0);
        add_frame(6, 4'b1110, 1'b1, 4'b1110, 1'b1, 3);
        add_frame(6, 4'b1110, 1'b1, 4'b1110, 1'b1, 1);
        add_frame(6, 4'b1110, 1'b1, 4'b1110, 1'b1, 2);
        add_frame(6, 4'b1111, 1'b1, 4'b1111, 1'b1, 0);
`else
        // 2: all requesting, order 0,1,2,3,0
        add_reset(2);
        for (int f = 0; f < 5; f++) begin
            add_frame(2, 4'b1111, 1'b1, 4'b1111, 1'b1, order2[f]);
        end

        // 3: wrap from rr_ptr=3 with req=0101
        add_reset(3);
        add_frame(3, 4'b0100, 1'b1, 4'b0100, 1'b1, 2);
        add_frame(3, 4'b0101, 1'b1, 4'b0101, 1'b1, 0);
        add_frame(3, 4'b0101, 1'b1, 4'b0101, 1'b1, 2);
        add_frame(3, 4'b0101, 1'b1, 4'b0101, 1'b1, 0);

        // 4a: enable drops during the frame; no new start while low
        add_frame(4, 4'b0001, 1'b1, 4'b0001, 1'b0, 0);
        for (int k = 0; k < 3; k++) add_idle(4, 1'b0, 4'b1111);
        // 4b: req drops mid-frame, done still pulsed
        add_frame(4, 4'b0010, 1'b1, 4'b0000, 1'b1, 1);
        for (int k = 0; k < 2; k++) add_idle(4, 1'b1, 4'b0000);

        // 5: reset during GAP, then lowest active requester wins
        add(5, 1'b1, 1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0000);
        for (int k = 0; k < F + 1; k++) begin
            add(5, 1'b1, 1'b1, 4'b1111, 4'b0100, 2'd2, 1'b0, 1'b1, 4'b0000);
        end
        add_reset(5);
        add_frame(5, 4'b1111, 1'b1, 4'b1111, 1'b1, 0);
`endif

        rst_n = 1'b0; enable = 1'b0; req = 4'b0000;
        @(posedge clk);
        #1;
        n_vec++;
        if ({gnt, sel, start, busy, done} !== 13'd0) begin
            n_err++;
            $display("FAIL reset state: gnt=%b sel=%0d start=%b busy=%b done=%b",
                     gnt, sel, start, busy, done);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n  = vecs[i].rst_n;
            enable = vecs[i].en;
            req    = vecs[i].req;
            @(posedge clk);
            #1;
            n_vec++;
            if ({gnt, sel, start, busy, done} !==
                {vecs[i].gnt, vecs[i].sel, vecs[i].start, vecs[i].busy, vecs[i].done}) begin
                n_err++;
                $display("FAIL test%0d row%0d: got gnt=%b sel=%0d start=%b busy=%b done=%b, want gnt=%b sel=%0d start=%b busy=%b done=%b",
                         vecs[i].tag, i, gnt, sel, start, busy, done, vecs[i].gnt,
                         vecs[i].sel, vecs[i].start, vecs[i].busy, vecs[i].done);
            end
        end

        run_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0) $display("TEST PASSED");
        else            $display("TEST FAILED");
        $finish;
    end

endmodule
